balance_display_driver: RTL and testbench

Parametrised driver that turns a binary balance into decimal digits and loads them into a bank of decade-counter display chips (one chip per digit, shared active-low clear). It sits between the balance register and the LED display hardware. It is the multi-digit, width-generic successor of the single-chain LED driver. New behaviour:
- sequential binary-to-BCD conversion;
- one-hot per-digit clock steering;
- programmable pulse timing;
- overflow saturation;
- a start/busy/done handshake.

---
 rtl/balance_display_driver_if.sv | 13 +
 rtl/balance_display_driver.sv | 187 ++++++++++++++++++
 tb/tb_balance_display_driver.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/balance_display_driver_if.sv
// Handshake bundle between the balance register owner and the display driver.
interface balance_display_driver_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] balance;
    logic             start;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (output balance, output start, input busy, input done, input overflow);
    modport slave  (input balance, input start, output busy, output done, output overflow);
endinterface

// File: rtl/balance_display_driver.sv
// Converts a binary balance to BCD by double-dabble and loads each digit into
// its decade-counter chip with a programmable-width pulse train.
module balance_display_driver #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DIGITS    = 10,
    parameter int unsigned PULSE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_neg,
    balance_display_driver_if.slave bus,
    output logic                 cclr_neg,
    output logic                 clk_out,
    output logic [DIGITS-1:0]    digit_sel,
    output logic [3:0]           num
);
    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned IT_W  = $clog2(WIDTH + 1);
    localparam int unsigned PH_W  = $clog2(2 * PULSE_CYC + 1);
    localparam int unsigned DG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_CLEAR, S_LOAD, S_SEND, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [DG_W-1:0]   dig_q, dig_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rdy_q;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cclr_q, cclr_d;
    logic              clk_q, clk_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [3:0]        num_q, num_d;

    logic [BCD_W-1:0]  adj;
    logic              carry;
    logic [3:0]        nib_cur;

    // Blocks a start that arrives on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) rdy_q <= 1'b0;
        else          rdy_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            iter_q  <= '0;
            ph_q    <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cclr_q  <= 1'b1;
            clk_q   <= 1'b0;
            sel_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            iter_q  <= iter_d;
            ph_q    <= ph_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cclr_q  <= cclr_d;
            clk_q   <= clk_d;
            sel_q   <= sel_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        iter_d  = iter_q;
        ph_d    = ph_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        carry   = 1'b0;
        adj     = '0;
        nib_cur = 4'd0;

        // Add-3 correction for every nibble, and the nibble of the current digit.
        for (int i = 0; i < DIGITS; i++) begin
            adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                       : bcd_q[i*4 +: 4];
            if (DG_W'(i) == dig_q) nib_cur = bcd_q[i*4 +: 4];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start && rdy_q) begin
                    state_d = S_CONV;
                    bin_d   = bus.balance;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    iter_d  = '0;
                end
            end
            S_CONV: begin
                carry  = adj[BCD_W-1];
                bcd_d  = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
                bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                ovf_d  = ovf_q | carry;
                iter_d = iter_q + IT_W'(1);
                if (iter_q == IT_W'(WIDTH - 1)) begin
                    state_d = S_CLEAR;
                    ph_d    = '0;
                    // Saturate the display at all nines when the value did not fit.
                    if (ovf_q || carry) bcd_d = {DIGITS{4'd9}};
                end
            end
            S_CLEAR: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == PH_W'(2 * PULSE_CYC - 1)) begin
                    state_d = S_LOAD;
                    ph_d    = '0;
                    dig_d   = '0;
                end
            end
            S_LOAD: begin
                cnt_d = nib_cur;
                if (nib_cur == 4'd0) begin
                    if (dig_q == DG_W'(DIGITS - 1)) state_d = S_FIN;
                    else                            dig_d   = dig_q + DG_W'(1);
                end else begin
                    state_d = S_SEND;
                    ph_d    = '0;
                end
            end
            S_SEND: begin
                ph_d = ph_q + PH_W'(1);
                if (ph_q == PH_W'(2 * PULSE_CYC - 1)) begin
                    ph_d  = '0;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (dig_q == DG_W'(DIGITS - 1)) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_LOAD;
                            dig_d   = dig_q + DG_W'(1);
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
        cclr_d = !((state_d == S_CLEAR) && (ph_d < PH_W'(PULSE_CYC)));
        clk_d  = (state_d == S_SEND) && (ph_d < PH_W'(PULSE_CYC));
        sel_d  = '0;
        num_d  = 4'd0;
        if (state_d == S_SEND) begin
            sel_d = DIGITS'(1) << dig_d;
            num_d = nib_cur;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign cclr_neg     = cclr_q;
    assign clk_out      = clk_q;
    assign digit_sel    = sel_q;
    assign num          = num_q;

endmodule

// File: tb/tb_balance_display_driver.sv
// Scoreboard bench: two driver instances (PULSE_CYC 1 and 3), expected run
// summaries queued at start, compared by a monitor when done fires.
module tb_balance_display_driver;
    localparam int unsigned W = 32;
    localparam int unsigned D = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_neg;

    balance_display_driver_if #(.WIDTH(W)) if0 ();
    balance_display_driver_if #(.WIDTH(W)) if1 ();

    logic         busy_w [2];
    logic         done_w [2];
    logic         ovf_w  [2];
    logic         cclr_w [2];
    logic         clko_w [2];
    logic [D-1:0] sel_w  [2];
    logic [3:0]   num_w  [2];

    assign busy_w[0] = if0.busy;  assign busy_w[1] = if1.busy;
    assign done_w[0] = if0.done;  assign done_w[1] = if1.done;
    assign ovf_w[0]  = if0.overflow; assign ovf_w[1] = if1.overflow;

    balance_display_driver #(.WIDTH(W), .DIGITS(D), .PULSE_CYC(1)) dut0 (
        .clk(clk), .rst_neg(rst_neg), .bus(if0),
        .cclr_neg(cclr_w[0]), .clk_out(clko_w[0]), .digit_sel(sel_w[0]), .num(num_w[0]));

    balance_display_driver #(.WIDTH(W), .DIGITS(D), .PULSE_CYC(3)) dut1 (
        .clk(clk), .rst_neg(rst_neg), .bus(if1),
        .cclr_neg(cclr_w[1]), .clk_out(clko_w[1]), .digit_sel(sel_w[1]), .num(num_w[1]));

    typedef struct packed {
        logic [D-1:0][7:0] cnt;
        logic              ovf;
        logic [15:0]       busy;
        logic [7:0]        clr;
        logic [7:0]        plen;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int done_tot [2] = '{0, 0};

    int                busy_c [2];
    int                clr_c  [2];
    int                viol   [2];
    int                hi     [2];
    int                lo     [2];
    logic              seen   [2];
    logic              prev_clk [2];
    logic [D-1:0]      prev_sel [2];
    logic [D-1:0][7:0] act    [2];

    exp_t hd;
    exp_t popped;
    logic have;
    int   idx;

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act_v, exp_v);
        end
    endtask

    function automatic exp_t mk(input int c0, c1, c2, c3, c4, c5,
                                input bit ovf, input int busy, clr, plen);
        exp_t e;
        e.cnt[0] = 8'(c0); e.cnt[1] = 8'(c1); e.cnt[2] = 8'(c2);
        e.cnt[3] = 8'(c3); e.cnt[4] = 8'(c4); e.cnt[5] = 8'(c5);
        e.ovf  = ovf;
        e.busy = 16'(busy);
        e.clr  = 8'(clr);
        e.plen = 8'(plen);
        return e;
    endfunction

    // Monitor: accumulates pulse statistics per run, compares on done.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_neg) begin
                busy_c[i] = 0; clr_c[i] = 0; viol[i] = 0; hi[i] = 0; lo[i] = 0;
                seen[i] = 1'b0; act[i] = '0; prev_clk[i] = 1'b0; prev_sel[i] = '0;
            end else begin
                have = 1'b0;
                hd   = '0;
                if (i == 0 && q0.size() > 0) begin hd = q0[0]; have = 1'b1; end
                if (i == 1 && q1.size() > 0) begin hd = q1[0]; have = 1'b1; end
                idx = 0;
                for (int j = 0; j < D; j++) if (sel_w[i][j]) idx = j;

                if (busy_w[i]) busy_c[i]++;
                if (!cclr_w[i]) clr_c[i]++;
                if (clko_w[i] && sel_w[i] == '0) viol[i]++;
                if (sel_w[i] != prev_sel[i] && prev_clk[i]) viol[i]++;
                if (sel_w[i] != '0 && !$onehot(sel_w[i])) viol[i]++;
                if (sel_w[i] == '0 && num_w[i] != 4'd0) viol[i]++;
                if (sel_w[i] != '0 && have && num_w[i] != hd.cnt[idx][3:0]) viol[i]++;
                if (sel_w[i] != prev_sel[i]) seen[i] = 1'b0;

                if (clko_w[i] && !prev_clk[i]) begin
                    act[i][idx] = act[i][idx] + 8'd1;
                    if (seen[i] && have && lo[i] != int'(hd.plen)) viol[i]++;
                    hi[i] = 1;
                end else if (clko_w[i]) begin
                    hi[i]++;
                end else if (prev_clk[i]) begin
                    if (have && hi[i] != int'(hd.plen)) viol[i]++;
                    lo[i]   = 1;
                    seen[i] = 1'b1;
                end else begin
                    lo[i]++;
                end

                if (done_w[i]) begin
                    done_tot[i]++;
                    if (!have) begin
                        chk($sformatf("unexpected_done%0d", i), 64'(done_w[i]), 64'(0));
                    end else begin
                        if (i == 0) popped = q0.pop_front();
                        else        popped = q1.pop_front();
                        chk($sformatf("pulse_counts%0d", i), 64'(act[i]), 64'(popped.cnt));
                        chk($sformatf("overflow%0d", i), 64'(ovf_w[i]), 64'(popped.ovf));
                        chk($sformatf("busy_cycles%0d", i), 64'(busy_c[i]), 64'(popped.busy));
                        chk($sformatf("clear_low%0d", i), 64'(clr_c[i]), 64'(popped.clr));
                        chk($sformatf("protocol_violations%0d", i), 64'(viol[i]), 64'(0));
                    end
                    busy_c[i] = 0; clr_c[i] = 0; viol[i] = 0; seen[i] = 1'b0; act[i] = '0;
                end
                prev_clk[i] = clko_w[i];
                prev_sel[i] = sel_w[i];
            end
        end
    end

    task automatic drive_start(input int i, input logic [W-1:0] v);
        @(posedge clk); #1;
        if (i == 0) begin if0.balance = v; if0.start = 1'b1; end
        else        begin if1.balance = v; if1.start = 1'b1; end
        @(posedge clk); #1;
        if0.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_w[i] && n < 3000);
        chk($sformatf("reach_idle%0d", i), 64'(busy_w[i]), 64'(0));
    endtask

    task automatic wait_sel(input int i, input int b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel_w[i][b] && n < 3000);
        chk($sformatf("reach_digit%0d", b), 64'(sel_w[i][b]), 64'(1));
    endtask

    task automatic run(input int i, input logic [W-1:0] v, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive_start(i, v);
        wait_idle(i);
    endtask

    initial begin
        rst_neg = 1'b0;
        if0.start = 1'b0; if0.balance = '0;
        if1.start = 1'b0; if1.balance = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs0", 64'({busy_w[0], done_w[0], ovf_w[0], cclr_w[0], clko_w[0], sel_w[0], num_w[0]}),
            64'({3'b000, 1'b1, 1'b0, 6'd0, 4'd0}));
        chk("reset_outputs1", 64'({busy_w[1], done_w[1], ovf_w[1], cclr_w[1], clko_w[1], sel_w[1], num_w[1]}),
            64'({3'b000, 1'b1, 1'b0, 6'd0, 4'd0}));

        // Start raised together with reset release must be ignored.
        @(posedge clk); #1;
        rst_neg = 1'b1; if0.balance = 32'd5; if0.start = 1'b1;
        @(posedge clk); #1;
        if0.start = 1'b0;
        @(negedge clk);
        chk("start_at_release", 64'(busy_w[0]), 64'(0));

        run(0, 32'd123456,  mk(6, 5, 4, 3, 2, 1, 1'b0, 83, 1, 1));
        run(0, 32'd0,       mk(0, 0, 0, 0, 0, 0, 1'b0, 41, 1, 1));
        run(0, 32'd1234567, mk(9, 9, 9, 9, 9, 9, 1'b1, 149, 1, 1));
        repeat (5) @(negedge clk);
        chk("overflow_hold", 64'(ovf_w[0]), 64'(1));

        q0.push_back(mk(9, 9, 9, 0, 0, 0, 1'b0, 95, 1, 1));
        drive_start(0, 32'd999);
        chk("overflow_cleared", 64'(ovf_w[0]), 64'(0));
        wait_idle(0);

        // Second start during SEND is dropped.
        q0.push_back(mk(6, 5, 4, 3, 2, 1, 1'b0, 83, 1, 1));
        drive_start(0, 32'd123456);
        wait_sel(0, 3);
        drive_start(0, 32'd999);
        wait_idle(0);

        // Asynchronous reset in the middle of digit 2.
        drive_start(0, 32'd123456);
        wait_sel(0, 2);
        #2 rst_neg = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({busy_w[0], done_w[0], ovf_w[0], cclr_w[0], clko_w[0], sel_w[0], num_w[0]}),
            64'({3'b000, 1'b1, 1'b0, 6'd0, 4'd0}));
        repeat (2) @(posedge clk);
        #1 rst_neg = 1'b1;

        run(0, 32'd42, mk(2, 4, 0, 0, 0, 0, 1'b0, 53, 1, 1));
        run(1, 32'd7,  mk(7, 0, 0, 0, 0, 0, 1'b0, 87, 3, 3));

        repeat (3) @(negedge clk);
        chk("done_count0", 64'(done_tot[0]), 64'(6));
        chk("done_count1", 64'(done_tot[1]), 64'(1));
        chk("scoreboard_empty", 64'(q0.size() + q1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
